mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM states, word size,
// and the alignment/range check applied to every request.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // An address is bad if it is not word aligned or its word index falls past the array.
  function automatic logic addr_err(input logic [31:0] adr, input int unsigned depth);
    return (adr[1:0] != 2'b00) || ({2'b00, adr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one synchronous read port with
// enable, no reset.
module mem_array #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // rdata_o only moves on an enabled read, so it holds across writes.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request in IDLE, waits WAIT_STATES cycles, then
// returns a one-cycle response with alignment/range error reporting.
//   state | meaning
//   IDLE  | ready; a valid request is accepted on the next edge
//   WAIT  | counting down the wait states for the captured request
//   RESP  | resp_valid strobe for one cycle, then back to IDLE
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        resp_valid,
  output logic        resp_err
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned BS       = $clog2(WORD_BYTES);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q;
  logic [31:0]   adr_q, wdata_q;
  logic          err_q, err_d;
  logic          rd_clr_q, rd_clr_d;

  logic          accept, enter_resp;
  logic          eff_write, eff_err;
  logic [31:0]   eff_adr, eff_wdata, mem_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_idx;

  // With zero wait states the array is accessed on the accepting edge itself,
  // so the live inputs stand in for the not-yet-captured registers.
  always_comb begin
    accept     = (state_q == IDLE) && req_valid;
    eff_write  = (state_q == IDLE) ? MemWrite  : write_q;
    eff_adr    = (state_q == IDLE) ? Adr       : adr_q;
    eff_wdata  = (state_q == IDLE) ? WriteData : wdata_q;
    eff_err    = addr_err(eff_adr, DEPTH_WORDS);
    enter_resp = (accept && (WAIT_STATES == 0)) ||
                 ((state_q == WAIT) && (cnt_q == 4'd0));
    mem_idx    = eff_adr[BS +: AW];
    mem_we     = reset && enter_resp && eff_write && !eff_err;
    mem_re     = reset && enter_resp && !eff_write && !eff_err;

    err_d    = err_q;
    rd_clr_d = rd_clr_q;
    if (enter_resp) begin
      err_d = eff_err;
      if (eff_err)         rd_clr_d = 1'b1;
      else if (!eff_write) rd_clr_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      adr_q    <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rd_clr_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_clr_q <= rd_clr_d;
      if (accept) begin
        write_q <= MemWrite;
        adr_q   <= Adr;
        wdata_q <= WriteData;
      end
    end
  end

  mem_array #(
    .DEPTH     (DEPTH_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_idx),
    .wdata_i (eff_wdata),
    .re_i    (mem_re),
    .raddr_i (mem_idx),
    .rdata_o (mem_rdata)
  );

  // rd_clr_q forces zero after reset and after an error until the next good read.
  assign ReadData   = rd_clr_q ? 32'd0 : mem_rdata;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states), directed vector
// table, multi-cycle corner sequences, and randomized traffic against a word model.
module tb_mem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;
  localparam int D0 = 64;
  localparam int D1 = 16;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]       rv, mw, rdy, rsp, rerr;
  logic [1:0][31:0] ad, wdat, rdat;

  int n_chk  = 0;
  int n_fail = 0;
  int lat_exp [2] = '{W0 + 1, W1 + 1};
  int dep     [2] = '{D0, D1};

  logic [31:0] mdl_mem [2][64];
  logic [31:0] mdl_rd  [2];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] xrd;
    logic        xerr;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] b2b_adr [4] = '{32'h4, 32'hFC, 32'h0, 32'h10};

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(D0), .WAIT_STATES(W0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]),
    .MemWrite(mw[0]), .Adr(ad[0]), .WriteData(wdat[0]),
    .ReadData(rdat[0]), .resp_valid(rsp[0]), .resp_err(rerr[0]));

  mem_responder #(.DEPTH_WORDS(D1), .WAIT_STATES(W1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]),
    .MemWrite(mw[1]), .Adr(ad[1]), .WriteData(wdat[1]),
    .ReadData(rdat[1]), .resp_valid(rsp[1]), .resp_err(rerr[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Reference behaviour: what one request should return, and its effect on storage.
  task automatic mdl_step(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] erd, output logic eerr);
    int unsigned idx;
    idx  = a / 4;
    eerr = ((a % 4) != 0) || (idx >= dep[d]);
    if (eerr)   mdl_rd[d] = 32'd0;
    else if (w) mdl_mem[d][idx] = wd;
    else        mdl_rd[d] = mdl_mem[d][idx];
    erd = mdl_rd[d];
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input string nm, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    rv[d] = 1'b1; mw[d] = w; ad[d] = a; wdat[d] = wd;
    n = 0;
    while (!rdy[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1({nm, " ready before accept"}, rdy[d], 1'b1);
    @(posedge clk);
    #1;
    rv[d] = 1'b0; mw[d] = ~w; ad[d] = $urandom(); wdat[d] = $urandom();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp[d] && lat < 40);
    rd = rdat[d];
    er = rerr[d];
    chk1({nm, " resp_valid seen"}, rsp[d], 1'b1);
    chk1({nm, " ready low in resp"}, rdy[d], 1'b0);
    @(negedge clk);
    chk1({nm, " strobe one cycle"}, rsp[d], 1'b0);
    chk1({nm, " err low when idle"}, rerr[d], 1'b0);
    chk1({nm, " ready after resp"}, rdy[d], 1'b1);
  endtask

  task automatic req_chk(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] xrd, input logic xerr, input string nm);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(d, w, a, wd, nm, rd, er, lat);
    chk({nm, " ReadData"}, rd, xrd);
    chk1({nm, " resp_err"}, er, xerr);
    chk({nm, " latency"}, 32'(lat), 32'(lat_exp[d]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] xrd, a;
    logic        xerr, saw;
    int          n, sp, sel, d;

    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h4,        32'h11111111, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h6,        32'h22222222, 32'h0,        1'b1};
    tbl[4]  = '{1'b0, 32'h4,        32'h0,        32'h11111111, 1'b0};
    tbl[5]  = '{1'b0, 32'h100,      32'h0,        32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'hFC,       32'hCAFEF00D, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 32'hFC,       32'h0,        32'hCAFEF00D, 1'b0};
    tbl[8]  = '{1'b1, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b0, 32'hFC,       32'h0,        32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b1, 32'h0,        32'h0BADF00D, 32'hCAFEF00D, 1'b0};
    tbl[11] = '{1'b1, 32'h100,      32'h55555555, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 32'h0,        32'h0,        32'h0BADF00D, 1'b0};

    rv = '0; mw = '0; ad = '0; wdat = '0;
    mdl_rd[0] = 32'd0; mdl_rd[1] = 32'd0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("reset ready[%0d]", i), rdy[i], 1'b1);
      chk1($sformatf("reset resp_valid[%0d]", i), rsp[i], 1'b0);
      chk1($sformatf("reset resp_err[%0d]", i), rerr[i], 1'b0);
      chk($sformatf("reset ReadData[%0d]", i), rdat[i], 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("ready first cycle after reset", rdy[0], 1'b1);

    for (int i = 0; i < 13; i++) begin
      mdl_step(0, tbl[i].w, tbl[i].a, tbl[i].wd, xrd, xerr);
      req_chk(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].xrd, tbl[i].xerr, $sformatf("vec%0d", i));
    end

    mdl_step(1, 1'b1, 32'h0, 32'h12345678, xrd, xerr);
    req_chk(1, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0, "ws0 write");
    mdl_step(1, 1'b0, 32'h0, 32'h0, xrd, xerr);
    req_chk(1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, "ws0 read");

    // Back-to-back reads with req_valid held; junk write fields while busy.
    @(negedge clk);
    rv[0] = 1'b1; mw[0] = 1'b0; ad[0] = b2b_adr[0]; wdat[0] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      mdl_step(0, 1'b0, b2b_adr[k], 32'h0, xrd, xerr);
      n = 0;
      while (!rdy[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      sp = n;
      @(posedge clk);
      #1;
      mw[0] = 1'b1; ad[0] = 32'h10; wdat[0] = $urandom();
      if (k == 3) rv[0] = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp[0] && n < 20);
      sp += n;
      chk($sformatf("b2b%0d ReadData", k), rdat[0], xrd);
      chk1($sformatf("b2b%0d resp_err", k), rerr[0], 1'b0);
      if (k > 0) chk($sformatf("b2b%0d spacing", k), 32'(sp), 32'(W0 + 2));
      if (k < 3) begin
        mw[0] = 1'b0; ad[0] = b2b_adr[k+1]; wdat[0] = $urandom();
      end
    end
    @(negedge clk);
    rv[0] = 1'b0;

    // Abort a write in WAIT with a one-cycle reset pulse.
    mdl_step(0, 1'b1, 32'h20, 32'h13579BDF, xrd, xerr);
    req_chk(0, 1'b1, 32'h20, 32'h13579BDF, xrd, xerr, "pre-abort write");
    @(negedge clk);
    rv[0] = 1'b1; mw[0] = 1'b1; ad[0] = 32'h20; wdat[0] = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    chk1("abort in wait ready", rdy[0], 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk1("async reset ready", rdy[0], 1'b1);
    chk1("async reset resp_valid", rsp[0], 1'b0);
    chk("async reset ReadData", rdat[0], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    mdl_rd[0] = 32'd0; mdl_rd[1] = 32'd0;
    #1;
    chk1("ready after abort release", rdy[0], 1'b1);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp[0]) saw = 1'b1;
    end
    chk1("no resp after abort", saw, 1'b0);
    mdl_step(0, 1'b0, 32'h20, 32'h0, xrd, xerr);
    req_chk(0, 1'b0, 32'h20, 32'h0, 32'h13579BDF, 1'b0, "read after abort");

    // Randomized traffic on both instances against the model.
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < dep[dd]; i++) begin
        a = 32'(i) * 4;
        mdl_step(dd, 1'b1, a, $urandom(), xrd, xerr);
        req_chk(dd, 1'b1, a, mdl_mem[dd][i], xrd, xerr, $sformatf("init%0d_%0d", dd, i));
      end
    end
    for (int i = 0; i < 120; i++) begin
      logic        w;
      logic [31:0] wd;
      d   = i % 2;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, dep[d] - 1)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, dep[d] - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(dep[d], dep[d] + 8)) << 2;
      else               a = $urandom() | 32'h80000000;
      w  = 1'($urandom_range(0, 1));
      wd = $urandom();
      mdl_step(d, w, a, wd, xrd, xerr);
      req_chk(d, w, a, wd, xrd, xerr, $sformatf("rnd%0d d%0d a%08h", i, d, a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
